// File: rtl/tdc_measure_ctrl.sv
// TDC measurement sequencer: arms the delay line, counts coarse cycles,
// waits for the fine decoder to settle, then holds the result until it is accepted.
module tdc_measure_ctrl #(
    parameter int COARSE_W      = 8,
    parameter int MAX_COARSE    = 255,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_req,
    input  logic                stop_hit,
    input  logic                abort,
    input  logic [7:0]          fine_code,
    input  logic                out_ready,
    output logic                line_arm,
    output logic                sample_en,
    output logic                busy,
    output logic [COARSE_W-1:0] result_coarse,
    output logic [7:0]          result_fine,
    output logic                result_timeout,
    output logic                result_valid
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SETTLE,
        HOLD
    } state_t;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [COARSE_W-1:0] MAX_C = COARSE_W'(MAX_COARSE);

    state_t              state;
    logic [COARSE_W-1:0] coarse_cnt;
    logic [COARSE_W-1:0] stop_cnt;
    logic [SW-1:0]       settle_cnt;

    // Sequencer; result_* only change when a result is committed on entry to HOLD,
    // so an abort mid-measurement leaves the previous result untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            coarse_cnt     <= '0;
            stop_cnt       <= '0;
            settle_cnt     <= '0;
            line_arm       <= 1'b0;
            sample_en      <= 1'b0;
            busy           <= 1'b0;
            result_coarse  <= '0;
            result_fine    <= '0;
            result_timeout <= 1'b0;
            result_valid   <= 1'b0;
        end else if (abort) begin
            state        <= IDLE;
            coarse_cnt   <= '0;
            settle_cnt   <= '0;
            line_arm     <= 1'b0;
            sample_en    <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            sample_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_req) begin
                        state      <= ARMED;
                        coarse_cnt <= '0;
                        line_arm   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ARMED: begin
                    if (stop_hit) begin
                        state      <= SETTLE;
                        stop_cnt   <= coarse_cnt;
                        settle_cnt <= '0;
                        line_arm   <= 1'b0;
                        sample_en  <= 1'b1;
                    end else if (coarse_cnt == MAX_C) begin
                        state          <= HOLD;
                        line_arm       <= 1'b0;
                        result_coarse  <= MAX_C;
                        result_fine    <= '0;
                        result_timeout <= 1'b1;
                        result_valid   <= 1'b1;
                    end else begin
                        coarse_cnt <= coarse_cnt + COARSE_W'(1);
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state          <= HOLD;
                        result_coarse  <= stop_cnt;
                        result_fine    <= fine_code;
                        result_timeout <= 1'b0;
                        result_valid   <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// Directed bench for tdc_measure_ctrl at default parameters.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_tdc_measure_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_req;
    logic       stop_hit;
    logic       abort;
    logic [7:0] fine_code;
    logic       out_ready;
    logic       line_arm;
    logic       sample_en;
    logic       busy;
    logic [7:0] result_coarse;
    logic [7:0] result_fine;
    logic       result_timeout;
    logic       result_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int seen_se;

    tdc_measure_ctrl #(
        .COARSE_W(8),
        .MAX_COARSE(255),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_req(start_req),
        .stop_hit(stop_hit),
        .abort(abort),
        .fine_code(fine_code),
        .out_ready(out_ready),
        .line_arm(line_arm),
        .sample_en(sample_en),
        .busy(busy),
        .result_coarse(result_coarse),
        .result_fine(result_fine),
        .result_timeout(result_timeout),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        start_req = 1'b0;
        stop_hit  = 1'b0;
        abort     = 1'b0;
        fine_code = 8'h00;
        out_ready = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_arm", line_arm, 0);
        check("rst_coarse", result_coarse, 0);
        check("rst_fine", result_fine, 0);
        check("rst_tmo", result_timeout, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Normal measurement: stop at cycle 6 with cnt=5
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        check("m1_busy", busy, 1);
        check("m1_arm", line_arm, 1);
        repeat (5) tick();
        stop_hit  = 1'b1;
        fine_code = 8'h47;
        tick();
        stop_hit = 1'b0;
        check("m1_se", sample_en, 1);
        check("m1_arm_off", line_arm, 0);
        check("m1_valid_early", result_valid, 0);
        tick();
        check("m1_se_off", sample_en, 0);
        check("m1_valid_t8", result_valid, 0);
        tick();
        check("m1_valid", result_valid, 1);
        check("m1_coarse", result_coarse, 5);
        check("m1_fine", result_fine, 8'h47);
        check("m1_tmo", result_timeout, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("m1_acc_valid", result_valid, 0);
        check("m1_acc_busy", busy, 0);
        check("m1_keep_coarse", result_coarse, 5);
        check("m1_keep_fine", result_fine, 8'h47);

        // Timeout: no stop for cnt 0..255
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        seen_se = 0;
        for (int i = 0; i < 256; i++) begin
            if (sample_en) seen_se++;
            check("to_pending", result_valid, 0);
            tick();
        end
        check("to_se_none", seen_se + sample_en, 0);
        check("to_valid", result_valid, 1);
        check("to_tmo", result_timeout, 1);
        check("to_coarse", result_coarse, 255);
        check("to_fine", result_fine, 0);
        check("to_arm", line_arm, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("to_acc", busy, 0);

        // Stop coincides with cnt=255: stop wins
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        repeat (255) tick();
        stop_hit  = 1'b1;
        fine_code = 8'h12;
        tick();
        stop_hit = 1'b0;
        check("eq_se", sample_en, 1);
        check("eq_valid_early", result_valid, 0);
        tick();
        tick();
        check("eq_valid", result_valid, 1);
        check("eq_tmo", result_timeout, 0);
        check("eq_coarse", result_coarse, 255);
        check("eq_fine", result_fine, 8'h12);

        // Hold stability while consumer stalls
        for (int i = 0; i < 10; i++) begin
            start_req = i[0];
            fine_code = 8'hA0 + 8'(i);
            tick();
            check("hold_valid", result_valid, 1);
            check("hold_coarse", result_coarse, 255);
            check("hold_fine", result_fine, 8'h12);
            check("hold_tmo", result_timeout, 0);
        end
        start_req = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_acc_valid", result_valid, 0);
        check("hold_acc_busy", busy, 0);
        tick();

        // Abort during SETTLE keeps previous result
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        repeat (2) tick();
        stop_hit  = 1'b1;
        fine_code = 8'h99;
        tick();
        stop_hit = 1'b0;
        abort    = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_arm", line_arm, 0);
        check("ab_se", sample_en, 0);
        check("ab_valid", result_valid, 0);
        check("ab_coarse", result_coarse, 255);
        check("ab_fine", result_fine, 8'h12);
        tick();
        check("ab_stay_idle", busy, 0);

        // Reset while ARMED clears everything immediately
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("rs_busy", busy, 0);
        check("rs_arm", line_arm, 0);
        check("rs_coarse", result_coarse, 0);
        check("rs_fine", result_fine, 0);
        tick();
        rst_n     = 1'b1;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        check("rs_first_start", busy, 1);
        check("rs_first_arm", line_arm, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("rs_abort_idle", busy, 0);

        // start and stop together in IDLE: stop ignored
        start_req = 1'b1;
        stop_hit  = 1'b1;
        tick();
        start_req = 1'b0;
        stop_hit  = 1'b0;
        check("ss_busy", busy, 1);
        check("ss_arm", line_arm, 1);
        check("ss_se", sample_en, 0);
        repeat (3) tick();
        stop_hit  = 1'b1;
        fine_code = 8'h3C;
        tick();
        stop_hit = 1'b0;
        check("ss_se_stop", sample_en, 1);
        tick();
        tick();
        check("ss_valid", result_valid, 1);
        check("ss_coarse", result_coarse, 3);
        check("ss_fine", result_fine, 8'h3C);
        check("ss_tmo", result_timeout, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
